// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin req/gnt arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-from-ptr priority encoder: first set req bit at or after ptr, wrapping.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  sel,
    output logic             valid
);

    always_comb begin
        sel   = '0;
        valid = |req;
        // Scan farthest offset first so the nearest set bit to ptr wins.
        for (int unsigned i = N_REQ; i > 0; i--) begin
            int unsigned idx;
            idx = (32'(ptr) + i - 1) % N_REQ;
            if (req[idx]) begin
                sel = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with bounded tenure and a one-cycle gap between owners.
// Optional ARB_STATS_EN adds saturating grant/timeout counters.
module rr_req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              busy,
`ifdef ARB_STATS_EN
    output logic [STAT_W-1:0] grant_count,
    output logic [STAT_W-1:0] timeout_count,
`endif
    output logic              timeout
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state;
    logic [ID_W-1:0]   ptr;
    logic [HC_W-1:0]   hold_cnt;
    logic [ID_W-1:0]   pick_sel;
    logic              pick_valid;
    logic [ID_W-1:0]   ptr_next;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    assign ptr_next = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
`ifdef ARB_STATS_EN
            grant_count   <= '0;
            timeout_count <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick_valid) begin
                        gnt      <= N_REQ'(1) << pick_sel;
                        gnt_id   <= pick_sel;
                        busy     <= 1'b1;
                        hold_cnt <= HC_W'(1);
                        state    <= GRANT;
`ifdef ARB_STATS_EN
                        if (grant_count != '1) grant_count <= grant_count + 1'b1;
`endif
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_next;
                        state <= GAP;
                    end else if (hold_cnt == HC_W'(MAX_HOLD)) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        ptr     <= ptr_next;
                        state   <= GAP;
`ifdef ARB_STATS_EN
                        if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed self-checking bench for rr_req_gnt_arbiter (N_REQ=4, MAX_HOLD=8).
module tb_rr_req_gnt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        timeout;
`ifdef ARB_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] timeout_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_req_gnt_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .busy          (busy),
`ifdef ARB_STATS_EN
        .grant_count   (grant_count),
        .timeout_count (timeout_count),
`endif
        .timeout       (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt, gnt_id, busy, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_release();
        do_reset(4'b0000);
        req = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL single_hold c%0d: gnt=%b id=%0d busy=%b to=%b, want 0001/0/1/0", c, gnt, gnt_id, busy, timeout);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%b busy=%b to=%b, want 0000/0/0", gnt, busy, timeout);
        end
    endtask

    task automatic test_timeout_sole();
        do_reset(4'b0000);
        req = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 8; c++) begin
                tick();
                checks++;
                if (gnt !== 4'b0100 || gnt_id !== 2'd2 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL sole_hold r%0d c%0d: gnt=%b id=%0d to=%b, want 0100/2/0", r, c, gnt, gnt_id, timeout);
                end
            end
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1) begin
                errors++;
                $display("FAIL sole_timeout r%0d: gnt=%b busy=%b to=%b, want 0000/0/1", r, gnt, busy, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL sole_regrant: gnt=%b to=%b, want 0100/0", gnt, timeout);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        do_reset(4'b1111);
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            for (int c = 1; c <= 8; c++) begin
                tick();
                checks++;
                if (gnt !== exp_gnt || gnt_id !== 2'(k % 4) || busy !== 1'b1 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_hold k%0d c%0d: gnt=%b id=%0d busy=%b to=%b, want %b/%0d/1/0",
                             k, c, gnt, gnt_id, busy, timeout, exp_gnt, k % 4);
                end
            end
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1 || gnt_id !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_gap k%0d: gnt=%b busy=%b to=%b id=%0d, want 0000/0/1/%0d",
                         k, gnt, busy, timeout, gnt_id, k % 4);
            end
        end
    endtask

    task automatic test_handoff();
        do_reset(4'b0000);
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL handoff_first: gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
        end
        req = 4'b1011;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL handoff_nonowner: gnt=%b, want 0010", gnt);
        end
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL handoff_gap: gnt=%b busy=%b to=%b id=%0d, want 0000/0/0/1", gnt, busy, timeout, gnt_id);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL handoff_next: gnt=%b id=%0d busy=%b, want 1000/3/1", gnt, gnt_id, busy);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(4'b0000);
        req = 4'b0010;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_pre: gnt=%b, want 0010", gnt);
        end
        rst = 1'b1;
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst: gnt=%b busy=%b to=%b id=%0d, want 0000/0/0/0", gnt, busy, timeout, gnt_id);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_after: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset(4'b1111);
        checks++;
        if (grant_count !== 16'd0 || timeout_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: grants=%0d timeouts=%0d, want 0/0", grant_count, timeout_count);
        end
        for (int c = 0; c < 40; c++) tick();
        checks++;
        if (grant_count !== 16'd5 || timeout_count !== 16'd4) begin
            errors++;
            $display("FAIL stats_40: grants=%0d timeouts=%0d, want 5/4", grant_count, timeout_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single_release();
        test_timeout_sole();
        test_round_robin();
        test_handoff();
        test_mid_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
